// File: rtl/regfile_dp_gen_if.sv
// Bus bundle for the dual-port register file. The master drives both ports'
// requests; the slave (the register file) returns read data and status.
interface regfile_dp_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int NB = DATA_W / 8;

  logic              ENA;
  logic              WENA;
  logic [NB-1:0]     BEA;
  logic [ADDR_W-1:0] ADDRA;
  logic [DATA_W-1:0] DINA;
  logic [DATA_W-1:0] QA;

  logic              ENB;
  logic              WENB;
  logic [NB-1:0]     BEB;
  logic [ADDR_W-1:0] ADDRB;
  logic [DATA_W-1:0] DINB;
  logic [DATA_W-1:0] QB;

  logic              BUSY;
  logic              COLLIDE;

  modport master (
    output ENA, WENA, BEA, ADDRA, DINA,
    output ENB, WENB, BEB, ADDRB, DINB,
    input  QA, QB, BUSY, COLLIDE
  );

  modport slave (
    input  ENA, WENA, BEA, ADDRA, DINA,
    input  ENB, WENB, BEB, ADDRB, DINB,
    output QA, QB, BUSY, COLLIDE
  );
endinterface

// File: rtl/regfile_dp_gen.sv
// True dual-port byte-lane register file with a post-reset clear sequencer.
// Port A wins overlapping lanes on a same-address dual write; COLLIDE flags it.
// Optional macro REGFILE_BYPASS_EN: a port reading the address the other port
// writes sees the new lanes instead of the old word.
//
// state | meaning
// CLEAR | zeroing one address per cycle, port requests ignored, BUSY=1
// READY | normal dual-port operation until the next reset
module regfile_dp_gen #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  regfile_dp_gen_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] qa_q, qa_d, qb_q, qb_d;
  logic              collide_q, collide_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready, zero_a, zero_b, wr_a, wr_b, same, dual;
  logic [DATA_W-1:0] old_a, old_b, wa_word, wb_word, rd_a, rd_b;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Request qualification and write-data merging for both ports
  always_comb begin
    ready   = (state_q == READY);
    zero_a  = ZERO_R0 && (rf.ADDRA == '0);
    zero_b  = ZERO_R0 && (rf.ADDRB == '0);
    wr_a    = ready && rf.ENA && rf.WENA && !zero_a;
    wr_b    = ready && rf.ENB && rf.WENB && !zero_b;
    same    = (rf.ADDRA == rf.ADDRB);
    dual    = wr_a && wr_b && same;
    old_a   = mem_q[rf.ADDRA];
    old_b   = mem_q[rf.ADDRB];
    wb_word = merge(old_b, rf.DINB, rf.BEB);
    // On a dual write A's lanes are laid over B's merge, so A wins overlaps.
    wa_word = dual ? merge(wb_word, rf.DINA, rf.BEA) : merge(old_a, rf.DINA, rf.BEA);
`ifdef REGFILE_BYPASS_EN
    rd_a    = (wr_b && same) ? merge(old_a, rf.DINB, rf.BEB) : old_a;
    rd_b    = (wr_a && same) ? merge(old_b, rf.DINA, rf.BEA) : old_b;
`else
    rd_a    = old_a;
    rd_b    = old_b;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    qa_d      = qa_q;
    qb_d      = qb_q;
    collide_d = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = READY;
      end
      READY: begin
        if (rf.ENA) begin
          if (zero_a)    qa_d = '0;
          else if (wr_a) qa_d = wa_word;
          else           qa_d = rd_a;
        end
        if (rf.ENB) begin
          if (zero_b)    qb_d = '0;
          else if (dual) qb_d = wa_word;
          else if (wr_b) qb_d = wb_word;
          else           qb_d = rd_b;
        end
        collide_d = dual && (|(rf.BEA & rf.BEB));
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      qa_q      <= '0;
      qb_q      <= '0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      qa_q      <= qa_d;
      qb_q      <= qb_d;
      collide_q <= collide_d;
    end
  end

  // Storage array: clear sweep, then port writes (A last so it wins on a dual write)
  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (wr_b) mem_q[rf.ADDRB] <= wb_word;
      if (wr_a) mem_q[rf.ADDRA] <= wa_word;
    end
  end

  assign rf.QA      = qa_q;
  assign rf.QB      = qb_q;
  assign rf.COLLIDE = collide_q;
  assign rf.BUSY    = (state_q == CLEAR);
endmodule

// File: tb/tb_regfile_dp_gen.sv
// Scoreboard bench for regfile_dp_gen: the driver pushes expected values tagged
// with the cycle they must appear; a monitor checks them just after each edge.
module tb_regfile_dp_gen;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  regfile_dp_gen_if #(.DATA_W(16), .ADDR_W(4)) ifm ();
  regfile_dp_gen_if #(.DATA_W(16), .ADDR_W(4)) ifz ();

  regfile_dp_gen #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .rf(ifm));
  regfile_dp_gen #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1)) dutz (
    .CLK(CLK), .RESET_N(RESET_N), .rf(ifz));

  typedef struct {
    int          due;
    int          code;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] ev);
    n_chk++;
    if (act !== ev) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, ev);
    end
  endtask

  function automatic logic [15:0] getv(input int code);
    case (code)
      0: return ifm.QA;
      1: return ifm.QB;
      2: return {15'd0, ifm.COLLIDE};
      3: return {15'd0, ifm.BUSY};
      4: return ifz.QA;
      5: return ifz.QB;
      6: return {15'd0, ifz.COLLIDE};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: after each rising edge, check every expectation due on this cycle
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          chk(sb[i].name, getv(sb[i].code), sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  task automatic ex(input int code, input logic [15:0] v, input string nm);
    exp_t e;
    e.due = cyc + 1; e.code = code; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic sm(input bit ena, input bit wena, input logic [1:0] bea,
                    input logic [3:0] aa, input logic [15:0] da,
                    input bit enb, input bit wenb, input logic [1:0] beb,
                    input logic [3:0] ab, input logic [15:0] db);
    ifm.ENA = ena; ifm.WENA = wena; ifm.BEA = bea; ifm.ADDRA = aa; ifm.DINA = da;
    ifm.ENB = enb; ifm.WENB = wenb; ifm.BEB = beb; ifm.ADDRB = ab; ifm.DINB = db;
  endtask

  task automatic sz(input bit ena, input bit wena, input logic [1:0] bea,
                    input logic [3:0] aa, input logic [15:0] da,
                    input bit enb, input bit wenb, input logic [1:0] beb,
                    input logic [3:0] ab, input logic [15:0] db);
    ifz.ENA = ena; ifz.WENA = wena; ifz.BEA = bea; ifz.ADDRA = aa; ifz.DINA = da;
    ifz.ENB = enb; ifz.WENB = wenb; ifz.BEB = beb; ifz.ADDRB = ab; ifz.DINB = db;
  endtask

  task automatic idle();
    sm(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    sz(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic [15:0] qa_hold;

  initial begin
    RESET_N = 1'b0;
    idle();
    #2;
    chk("rst_qa", ifm.QA, 16'h0);
    chk("rst_qb", ifm.QB, 16'h0);
    chk("rst_collide", {15'd0, ifm.COLLIDE}, 16'h0);
    chk("rst_busy", {15'd0, ifm.BUSY}, 16'h1);
    tick(); tick();
    RESET_N = 1'b1;

    // Clear sequence: BUSY for exactly 16 cycles; writes attempted mid-clear are dropped
    for (int i = 1; i <= 16; i++) begin
      if (i >= 3 && i <= 8)
        sm(1, 1, 2'b11, 4'd0, 16'hFFFF, 1, 1, 2'b11, 4'd1, 16'hFFFF);
      else
        idle();
      ex(3, (i < 16) ? 16'h1 : 16'h0, "clear_busy");
      ex(0, 16'h0, "clear_qa_zero");
      ex(1, 16'h0, "clear_qb_zero");
      ex(2, 16'h0, "clear_no_collide");
      tick();
    end
    sm(1, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd1, 16'h0);
    ex(0, 16'h0, "post_clear_rd0");
    ex(1, 16'h0, "post_clear_rd1");
    tick();
    sm(1, 0, 2'b00, 4'd7, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    ex(0, 16'h0, "post_clear_rd7");
    tick();

    // Reset reasserted at clear cycle 7 restarts a full 16-cycle clear
    idle();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      ex(3, 16'h1, "midclr_busy_pre");
      tick();
    end
    RESET_N = 1'b0;
    #1;
    chk("midclr_rst_qa", ifm.QA, 16'h0);
    chk("midclr_rst_qb", ifm.QB, 16'h0);
    chk("midclr_rst_busy", {15'd0, ifm.BUSY}, 16'h1);
    tick();
    RESET_N = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      ex(3, (i < 16) ? 16'h1 : 16'h0, "midclr_busy");
      tick();
    end

    // Byte-lane write with write-through, then cross-port read-back
    sm(1, 1, 2'b11, 4'd3, 16'h1234, 0, 0, 2'b00, 4'd0, 16'h0);
    ex(0, 16'h1234, "bl_init");
    tick();
    sm(1, 1, 2'b10, 4'd3, 16'hABCD, 0, 0, 2'b00, 4'd0, 16'h0);
    ex(0, 16'hAB34, "bl_merge_qa");
    tick();
    sm(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd3, 16'h0);
    ex(1, 16'hAB34, "bl_readback_qb");
    ex(0, 16'hAB34, "ena0_holds_qa");
    tick();
    sm(1, 1, 2'b00, 4'd3, 16'hFFFF, 0, 0, 2'b00, 4'd0, 16'h0);
    ex(0, 16'hAB34, "be0_write_is_read");
    tick();

    // Dual write, same address, overlapping lanes: A wins, COLLIDE pulses
    sm(1, 1, 2'b01, 4'd5, 16'h1111, 1, 1, 2'b11, 4'd5, 16'h2222);
    ex(0, 16'h2211, "coll_qa");
    ex(1, 16'h2211, "coll_qb");
    ex(2, 16'h1, "coll_flag");
    tick();
    idle();
    ex(2, 16'h0, "coll_pulse_end");
    tick();
    sm(1, 1, 2'b01, 4'd5, 16'h1111, 1, 1, 2'b10, 4'd5, 16'h2222);
    ex(0, 16'h2211, "nocoll_qa");
    ex(1, 16'h2211, "nocoll_qb");
    ex(2, 16'h0, "nocoll_flag");
    tick();
    sm(1, 0, 2'b00, 4'd5, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    ex(0, 16'h2211, "coll_mem5");
    tick();

    // Dual write to different addresses
    sm(1, 1, 2'b11, 4'd6, 16'h6666, 1, 1, 2'b11, 4'd7, 16'h7777);
    ex(0, 16'h6666, "diff_qa");
    ex(1, 16'h7777, "diff_qb");
    ex(2, 16'h0, "diff_collide");
    tick();
    sm(1, 0, 2'b00, 4'd7, 16'h0, 1, 0, 2'b00, 4'd6, 16'h0);
    ex(0, 16'h7777, "diff_rd7");
    ex(1, 16'h6666, "diff_rd6");
    tick();

    // Cross-port read during write
    sm(1, 1, 2'b11, 4'd9, 16'h0F0F, 0, 0, 2'b00, 4'd0, 16'h0);
    ex(0, 16'h0F0F, "xp_init");
    tick();
    sm(1, 1, 2'b11, 4'd9, 16'h5555, 1, 0, 2'b00, 4'd9, 16'h0);
    ex(0, 16'h5555, "xp_qa");
    ex(1, BYP ? 16'h5555 : 16'h0F0F, "xp_qb_same_cycle");
    tick();
    sm(0, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd9, 16'h0);
    ex(1, 16'h5555, "xp_qb_next");
    tick();
    qa_hold = BYP ? 16'h00AA : 16'h0000;
    sm(1, 0, 2'b00, 4'd10, 16'h0, 1, 1, 2'b01, 4'd10, 16'hAAAA);
    ex(0, qa_hold, "xp_b_wr_qa");
    ex(1, 16'h00AA, "xp_b_wr_qb");
    tick();
    idle();
    ex(0, qa_hold, "idle_holds_qa");
    ex(1, 16'h00AA, "idle_holds_qb");
    tick();

    // ZERO_R0 instance: address 0 is read-only zero and never collides
    sz(1, 1, 2'b11, 4'd0, 16'hFFFF, 1, 1, 2'b11, 4'd0, 16'hFFFF);
    ex(4, 16'h0, "z_wr0_qa");
    ex(5, 16'h0, "z_wr0_qb");
    ex(6, 16'h0, "z_wr0_collide");
    tick();
    sz(1, 0, 2'b00, 4'd0, 16'h0, 1, 0, 2'b00, 4'd0, 16'h0);
    ex(4, 16'h0, "z_rd0_qa");
    ex(5, 16'h0, "z_rd0_qb");
    ex(6, 16'h0, "z_rd0_collide");
    tick();
    sz(1, 1, 2'b11, 4'd2, 16'hBEEF, 1, 1, 2'b11, 4'd2, 16'h1234);
    ex(4, 16'hBEEF, "z_coll2_qa");
    ex(6, 16'h1, "z_coll2_flag");
    tick();
    sz(1, 0, 2'b00, 4'd2, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    ex(4, 16'hBEEF, "z_rd2");
    tick();

    idle();
    tick();
    tick();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
